// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - accelerator interface types, operation kinds and opcode constants
package acc_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  // Major opcodes that carry memory semantics on the accelerator side
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000111;
  localparam logic [6:0] OPCODE_STORE = 7'b0100111;

  typedef enum logic [1:0] {
    COMPUTE = 2'd0,
    LOAD    = 2'd1,
    STORE   = 2'd2
  } acc_kind_e;

  typedef struct packed {
    logic                     req_valid;
    logic                     resp_ready;
    logic [31:0]              insn;
    logic [XLEN-1:0]          rs1;
    logic [XLEN-1:0]          rs2;
    logic [2:0]               frm;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     acc_cons_en;
    logic                     inval_ready;
  } accelerator_req_t;

  typedef struct packed {
    logic                     req_ready;
    logic                     resp_valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    logic                     fflags_valid;
    logic [4:0]               fflags;
    logic                     error;
    logic                     store_pending;
    logic                     store_complete;
    logic                     load_complete;
    logic                     inval_valid;
    logic [63:0]              inval_addr;
  } accelerator_resp_t;

  // One tracker slot per outstanding request
  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    acc_kind_e                kind;
    logic                     cons_en;
  } tracker_entry_t;

  function automatic acc_kind_e classify_opcode(input logic [6:0] opcode);
    case (opcode)
      OPCODE_LOAD:  return LOAD;
      OPCODE_STORE: return STORE;
      default:      return COMPUTE;
    endcase
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous FIFO with optional fall-through, power-of-two depth
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             drop all entries
//   full_o, empty_o     occupancy flags
//   data_i, push_i      write side (push ignored when full)
//   data_o, pop_i       read side, data_o is the head entry (pop ignored when empty)
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter type         dtype        = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dtype              mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              bypass;
  logic              do_push;
  logic              do_pop;

  // In fall-through mode a push into an empty FIFO is visible on data_o at once;
  // if it is also popped in that cycle it never touches the storage.
  assign bypass  = FALL_THROUGH && (count_q == '0) && push_i;
  assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0) && !bypass;
  assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && !full_o && !(bypass && pop_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (ADDR_W+1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/acc_responder.sv
// rtl/acc_responder.sv - accelerator-side endpoint of the core accelerator request/response interface
//
// Accepts requests in order, issues them to the back-end through a one-entry
// issue register, tracks outstanding requests in a fifo_v3 and returns one
// response per request in order, with store/load bookkeeping.
//
// Build option: ACC_RESP_INVAL_EN adds the cache-invalidation handshake for
// consistency-enabled stores (inval_valid/inval_addr); without it both are 0.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   acc_req_i / acc_resp_o     core request / response structs
//   be_valid_o, be_ready_i     back-end issue handshake
//   be_insn_o .. be_kind_o     issued operation (insn, operands, rounding mode, kind)
//   be_done_i, be_done_ready_o completion handshake for the oldest issued operation
//   be_result_i .. be_fflags_i completion payload
//   be_st_addr_i               line address written by a completing store
module acc_responder
  import acc_pkg::*;
#(
  parameter type         acc_req_t  = acc_pkg::accelerator_req_t,
  parameter type         acc_resp_t = acc_pkg::accelerator_resp_t,
  parameter int unsigned Depth      = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  acc_req_t        acc_req_i,
  output acc_resp_t       acc_resp_o,
  output logic            be_valid_o,
  input  logic            be_ready_i,
  output logic [31:0]     be_insn_o,
  output logic [XLEN-1:0] be_rs1_o,
  output logic [XLEN-1:0] be_rs2_o,
  output logic [2:0]      be_frm_o,
  output acc_kind_e       be_kind_o,
  input  logic            be_done_i,
  output logic            be_done_ready_o,
  input  logic [XLEN-1:0] be_result_i,
  input  logic            be_exception_i,
  input  logic            be_fflags_valid_i,
  input  logic [4:0]      be_fflags_i,
  input  logic [63:0]     be_st_addr_i
);

  localparam int unsigned CNT_W = $clog2(Depth + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INVAL = 2'd1,
    RESP  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Request acceptance and tracker
  // ---------------------------------------------------------------------------
  logic           tracker_full;
  logic           tracker_empty;
  tracker_entry_t push_entry;
  tracker_entry_t tracker_head;
  acc_kind_e      req_kind;
  logic           req_ready;
  logic           req_accept;
  logic           resp_hs;

  logic           issue_valid_q;

  assign req_kind   = classify_opcode(acc_req_i.insn[6:0]);
  // The issue register may be refilled in the cycle the back-end takes it
  assign req_ready  = !tracker_full && (!issue_valid_q || be_ready_i);
  assign req_accept = acc_req_i.req_valid && req_ready;
  assign push_entry = '{trans_id: acc_req_i.trans_id, kind: req_kind, cons_en: acc_req_i.acc_cons_en};

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (Depth),
    .dtype        (tracker_entry_t)
  ) i_tracker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (tracker_full),
    .empty_o (tracker_empty),
    .data_i  (push_entry),
    .push_i  (req_accept),
    .data_o  (tracker_head),
    .pop_i   (resp_hs)
  );

  // ---------------------------------------------------------------------------
  // Issue register
  // ---------------------------------------------------------------------------
  logic [31:0]     issue_insn_q;
  logic [XLEN-1:0] issue_rs1_q;
  logic [XLEN-1:0] issue_rs2_q;
  logic [2:0]      issue_frm_q;
  acc_kind_e       issue_kind_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_valid_q <= 1'b0;
      issue_insn_q  <= '0;
      issue_rs1_q   <= '0;
      issue_rs2_q   <= '0;
      issue_frm_q   <= '0;
      issue_kind_q  <= COMPUTE;
    end else if (req_accept) begin
      issue_valid_q <= 1'b1;
      issue_insn_q  <= acc_req_i.insn;
      issue_rs1_q   <= acc_req_i.rs1;
      issue_rs2_q   <= acc_req_i.rs2;
      issue_frm_q   <= acc_req_i.frm;
      issue_kind_q  <= req_kind;
    end else if (be_ready_i) begin
      issue_valid_q <= 1'b0;
    end
  end

  assign be_valid_o = issue_valid_q;
  assign be_insn_o  = issue_insn_q;
  assign be_rs1_o   = issue_rs1_q;
  assign be_rs2_o   = issue_rs2_q;
  assign be_frm_o   = issue_frm_q;
  assign be_kind_o  = issue_kind_q;

  // ---------------------------------------------------------------------------
  // Completion FSM
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic            done_ready_q;
  logic            resp_valid_q;
  tracker_entry_t  cap_entry_q;
  logic [XLEN-1:0] cap_result_q;
  logic            cap_exc_q;
  logic            cap_ffv_q;
  logic [4:0]      cap_ff_q;
`ifdef ACC_RESP_INVAL_EN
  logic            inval_valid_q;
  logic [63:0]     inval_addr_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      done_ready_q  <= 1'b1;
      resp_valid_q  <= 1'b0;
      cap_entry_q   <= '0;
      cap_result_q  <= '0;
      cap_exc_q     <= 1'b0;
      cap_ffv_q     <= 1'b0;
      cap_ff_q      <= '0;
`ifdef ACC_RESP_INVAL_EN
      inval_valid_q <= 1'b0;
      inval_addr_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (be_done_i) begin
            cap_entry_q  <= tracker_head;
            cap_result_q <= be_result_i;
            cap_exc_q    <= be_exception_i;
            cap_ffv_q    <= be_fflags_valid_i;
            cap_ff_q     <= be_fflags_i;
            done_ready_q <= 1'b0;
`ifdef ACC_RESP_INVAL_EN
            if (tracker_head.kind == STORE && tracker_head.cons_en) begin
              state_q       <= INVAL;
              inval_valid_q <= 1'b1;
              inval_addr_q  <= be_st_addr_i;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end
`else
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
`endif
          end
        end
`ifdef ACC_RESP_INVAL_EN
        INVAL: begin
          if (acc_req_i.inval_ready) begin
            inval_valid_q <= 1'b0;
            state_q       <= RESP;
            resp_valid_q  <= 1'b1;
          end
        end
`endif
        RESP: begin
          if (acc_req_i.resp_ready) begin
            resp_valid_q <= 1'b0;
            done_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          done_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign be_done_ready_o = done_ready_q;
  assign resp_hs         = resp_valid_q && acc_req_i.resp_ready;

  logic store_complete;
  logic load_complete;

  assign store_complete = resp_hs && (cap_entry_q.kind == STORE);
  assign load_complete  = resp_hs && (cap_entry_q.kind == LOAD);

  // ---------------------------------------------------------------------------
  // Outstanding-store counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] store_cnt_q;
  logic             st_inc;
  logic             st_dec;

  assign st_inc = req_accept && (req_kind == STORE);
  assign st_dec = store_complete;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      store_cnt_q <= '0;
    end else if (st_inc && !st_dec) begin
      store_cnt_q <= store_cnt_q + CNT_W'(1);
    end else if (st_dec && !st_inc) begin
      store_cnt_q <= store_cnt_q - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Response
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_resp_o                = '0;
    acc_resp_o.req_ready      = req_ready;
    acc_resp_o.resp_valid     = resp_valid_q;
    acc_resp_o.trans_id       = cap_entry_q.trans_id;
    acc_resp_o.result         = cap_result_q;
    acc_resp_o.error          = cap_exc_q;
    acc_resp_o.fflags_valid   = cap_ffv_q;
    acc_resp_o.fflags         = cap_ff_q;
    acc_resp_o.store_pending  = (store_cnt_q != '0);
    acc_resp_o.store_complete = store_complete;
    acc_resp_o.load_complete  = load_complete;
`ifdef ACC_RESP_INVAL_EN
    acc_resp_o.inval_valid    = inval_valid_q;
    acc_resp_o.inval_addr     = inval_addr_q;
`endif
  end

`ifndef ACC_RESP_INVAL_EN
  // Invalidation inputs have no function in this build
  logic unused_inval;
  assign unused_inval = ^{be_st_addr_i, acc_req_i.inval_ready, cap_entry_q.cons_en};
`endif

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  assert property (@(posedge clk_i) disable iff (!rst_ni) be_done_i |-> !tracker_empty);
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(st_inc && !st_dec && store_cnt_q == CNT_W'(Depth)));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(st_dec && !st_inc && store_cnt_q == '0));

endmodule

// File: tb/tb_acc_responder.sv
// tb/tb_acc_responder.sv - randomized self-checking bench for acc_responder
module tb_acc_responder;
  import acc_pkg::*;

  localparam int DEPTH = 4;
`ifdef ACC_RESP_INVAL_EN
  localparam bit INVAL_EN = 1'b1;
`else
  localparam bit INVAL_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  accelerator_req_t  req;
  accelerator_resp_t resp;
  logic              be_valid_o;
  logic              be_ready_i;
  logic [31:0]       be_insn_o;
  logic [63:0]       be_rs1_o;
  logic [63:0]       be_rs2_o;
  logic [2:0]        be_frm_o;
  acc_kind_e         be_kind_o;
  logic              be_done_i;
  logic              be_done_ready_o;
  logic [63:0]       be_result_i;
  logic              be_exception_i;
  logic              be_fflags_valid_i;
  logic [4:0]        be_fflags_i;
  logic [63:0]       be_st_addr_i;

  always #5 clk_i = ~clk_i;

  acc_responder #(.Depth(DEPTH)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .acc_req_i         (req),
    .acc_resp_o        (resp),
    .be_valid_o        (be_valid_o),
    .be_ready_i        (be_ready_i),
    .be_insn_o         (be_insn_o),
    .be_rs1_o          (be_rs1_o),
    .be_rs2_o          (be_rs2_o),
    .be_frm_o          (be_frm_o),
    .be_kind_o         (be_kind_o),
    .be_done_i         (be_done_i),
    .be_done_ready_o   (be_done_ready_o),
    .be_result_i       (be_result_i),
    .be_exception_i    (be_exception_i),
    .be_fflags_valid_i (be_fflags_valid_i),
    .be_fflags_i       (be_fflags_i),
    .be_st_addr_i      (be_st_addr_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: requests accepted and not yet answered, in order
  typedef struct {
    logic [2:0]  tid;
    acc_kind_e   kind;
    bit          cons;
    logic [31:0] insn;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [2:0]  frm;
  } op_t;

  op_t         outq[$];
  bit          iss_valid;
  op_t         iss_op;
  int          be_out;      // handed to back-end, not yet completed
  int          phase;       // 0 waiting for completion, 1 invalidating, 2 responding
  op_t         cur;
  logic [63:0] cur_res;
  logic        cur_exc;
  logic        cur_ffv;
  logic [4:0]  cur_ff;
  logic [63:0] cur_addr;

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic op_t rand_op(input int kind_sel, input int cons_pct);
    op_t        o;
    logic [6:0] opc;
    int         k;
    k = (kind_sel == 0) ? int'($urandom_range(2, 0)) : kind_sel;
    case (k)
      1:       begin o.kind = LOAD;  opc = 7'b0000111; end
      2:       begin o.kind = STORE; opc = 7'b0100111; end
      default: begin
        o.kind = COMPUTE;
        opc = 7'($urandom);
        if (opc == 7'b0000111 || opc == 7'b0100111) opc = 7'b1010111;
      end
    endcase
    o.insn      = $urandom;
    o.insn[6:0] = opc;
    o.tid       = 3'($urandom);
    o.cons      = pct(cons_pct);
    o.rs1       = {$urandom, $urandom};
    o.rs2       = {$urandom, $urandom};
    o.frm       = 3'($urandom);
    return o;
  endfunction

  task automatic quiet_inputs();
    req               = '0;
    be_ready_i        = 1'b0;
    be_done_i         = 1'b0;
    be_result_i       = '0;
    be_exception_i    = 1'b0;
    be_fflags_valid_i = 1'b0;
    be_fflags_i       = '0;
    be_st_addr_i      = '0;
  endtask

  task automatic model_clear();
    outq.delete();
    iss_valid = 1'b0;
    be_out    = 0;
    phase     = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".req_ready"}, resp.req_ready, 1'b1);
    check_eq({tag, ".resp_valid"}, resp.resp_valid, 1'b0);
    check_eq({tag, ".be_valid"}, be_valid_o, 1'b0);
    check_eq({tag, ".done_ready"}, be_done_ready_o, 1'b1);
    check_eq({tag, ".store_pending"}, resp.store_pending, 1'b0);
    check_eq({tag, ".store_complete"}, resp.store_complete, 1'b0);
    check_eq({tag, ".load_complete"}, resp.load_complete, 1'b0);
    check_eq({tag, ".inval_valid"}, resp.inval_valid, 1'b0);
  endtask

  task automatic one_cycle(input int p_req, input int p_brdy, input int p_done,
                           input int p_rrdy, input int p_irdy, input int kind_sel,
                           input int cons_pct);
    op_t nop;
    bit  exp_ready, acc, hs;
    int  nst;
    @(negedge clk_i);
    nop               = rand_op(kind_sel, cons_pct);
    req.req_valid     = pct(p_req);
    req.insn          = nop.insn;
    req.rs1           = nop.rs1;
    req.rs2           = nop.rs2;
    req.frm           = nop.frm;
    req.trans_id      = nop.tid;
    req.acc_cons_en   = nop.cons;
    req.resp_ready    = pct(p_rrdy);
    req.inval_ready   = pct(p_irdy);
    be_ready_i        = pct(p_brdy);
    be_done_i         = (phase == 0 && be_out > 0) ? pct(p_done) : 1'b0;
    be_result_i       = {$urandom, $urandom};
    be_exception_i    = pct(20);
    be_fflags_valid_i = pct(50);
    be_fflags_i       = 5'($urandom);
    be_st_addr_i      = {$urandom, $urandom} & ~64'h3f;
    #1;
    exp_ready = (outq.size() < DEPTH) && (!iss_valid || be_ready_i);
    acc       = req.req_valid && exp_ready;
    hs        = (phase == 2) && req.resp_ready;
    nst       = 0;
    foreach (outq[i]) if (outq[i].kind == STORE) nst++;

    check_eq("req_ready", resp.req_ready, exp_ready);
    check_eq("be_valid", be_valid_o, iss_valid);
    check_eq("done_ready", be_done_ready_o, phase == 0);
    check_eq("resp_valid", resp.resp_valid, phase == 2);
    check_eq("inval_valid", resp.inval_valid, phase == 1);
    check_eq("store_pending", resp.store_pending, nst != 0);
    check_eq("store_complete", resp.store_complete, hs && cur.kind == STORE);
    check_eq("load_complete", resp.load_complete, hs && cur.kind == LOAD);
    if (iss_valid) begin
      check_eq("be_insn", be_insn_o, iss_op.insn);
      check_eq("be_rs1", be_rs1_o, iss_op.rs1);
      check_eq("be_rs2", be_rs2_o, iss_op.rs2);
      check_eq("be_frm", be_frm_o, iss_op.frm);
      check_eq("be_kind", be_kind_o, iss_op.kind);
    end
    if (phase == 2) begin
      check_eq("resp_trans_id", resp.trans_id, cur.tid);
      check_eq("resp_result", resp.result, cur_res);
      check_eq("resp_error", resp.error, cur_exc);
      check_eq("resp_fflags_valid", resp.fflags_valid, cur_ffv);
      check_eq("resp_fflags", resp.fflags, cur_ff);
    end
    if (phase == 1) check_eq("inval_addr", resp.inval_addr, cur_addr);

    @(posedge clk_i);
    if (hs) begin
      void'(outq.pop_front());
      phase = 0;
    end else if (phase == 1 && req.inval_ready) begin
      phase = 2;
    end else if (phase == 0 && be_done_i) begin
      cur      = outq[0];
      cur_res  = be_result_i;
      cur_exc  = be_exception_i;
      cur_ffv  = be_fflags_valid_i;
      cur_ff   = be_fflags_i;
      cur_addr = be_st_addr_i;
      phase    = (INVAL_EN && cur.kind == STORE && cur.cons) ? 1 : 2;
      be_out--;
    end
    if (iss_valid && be_ready_i) begin
      be_out++;
      iss_valid = 1'b0;
    end
    if (acc) begin
      outq.push_back(nop);
      iss_valid = 1'b1;
      iss_op    = nop;
    end
  endtask

  task automatic run_phase(input int cycles, input int p_req, input int p_brdy,
                           input int p_done, input int p_rrdy, input int p_irdy,
                           input int kind_sel, input int cons_pct);
    for (int c = 0; c < cycles; c++)
      one_cycle(p_req, p_brdy, p_done, p_rrdy, p_irdy, kind_sel, cons_pct);
  endtask

  initial begin
    quiet_inputs();
    model_clear();
    cur    = rand_op(0, 0);
    rst_ni = 1'b0;
    #23;
    check_reset_values("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // mixed traffic
    run_phase(1500, 60, 70, 50, 70, 50, 0, 50);
    // loads with completion held off: tracker fills and blocks requests
    run_phase(30, 100, 100, 0, 100, 100, 1, 0);
    run_phase(40, 0, 100, 100, 100, 100, 1, 0);
    // store-heavy: accepts overlap completions, slow invalidation
    run_phase(600, 70, 80, 60, 50, 30, 2, 80);
    // drain, then build up consistency stores stuck in invalidation
    run_phase(60, 0, 100, 100, 100, 100, 0, 0);
    run_phase(12, 100, 100, 100, 100, 0, 2, 100);

    // asynchronous reset in the middle of a cycle
    @(negedge clk_i);
    quiet_inputs();
    #2 rst_ni = 1'b0;
    #1 check_reset_values("async_reset");
    model_clear();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // traffic after reset must carry no stale responses
    run_phase(300, 60, 70, 50, 70, 50, 0, 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
